// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Package    : branch_pkg
// Description: Shared types for the branch resolve unit: the conditional
//              branch funct3 encodings, the BHT counter type with its reset
//              value, and the saturating counter update function.
// Revision   : 1.0 - initial release
// ============================================================================
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken.
  localparam bht_ctr_t BHT_RESET_CTR = 2'b01;

  // 2-bit saturating counter: taken moves towards 11, not-taken towards 00.
  function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// ============================================================================
// Module     : branch_bht
// Description: Branch history table of 2-bit saturating counters with one
//              combinational lookup port and one synchronous train port.
//              A lookup on the entry being trained returns the value held
//              before the update.
// Ports      : clock, nReset     - clock, asynchronous active-low reset
//              lk_idx_i          - lookup index
//              lk_taken_o        - prediction (counter MSB) at lk_idx_i
//              tr_en_i           - train strobe
//              tr_idx_i          - entry to train
//              tr_taken_i        - resolved direction used for training
// Revision   : 1.0 - initial release
// ============================================================================
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX         = $clog2(BHT_ENTRIES)
) (
  input  logic           clock,
  input  logic           nReset,
  input  logic [IDX-1:0] lk_idx_i,
  output logic           lk_taken_o,
  input  logic           tr_en_i,
  input  logic [IDX-1:0] tr_idx_i,
  input  logic           tr_taken_i
);

  // Prediction bit of every entry, gathered so the lookup is a plain mux.
  logic [BHT_ENTRIES-1:0] w_msb;

  generate
    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_ctr
      bht_ctr_t ctr_q;

      always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
          ctr_q <= BHT_RESET_CTR;
        end else if (tr_en_i && (tr_idx_i == IDX'(g))) begin
          ctr_q <= bht_ctr_next(ctr_q, tr_taken_i);
        end
      end

      assign w_msb[g] = ctr_q[1];
    end
  endgenerate

  assign lk_taken_o = w_msb[lk_idx_i];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module     : branch_resolve_unit
// Description: Execute-stage resolver for the six RV32I conditional branches.
//              Computes the condition, the redirect PC and the mispredict
//              flag, registers them in a one-entry valid/ready output stage,
//              and trains a 2-bit BHT on every retiring legal branch.
// Ports      : clock, nReset        - clock, asynchronous active-low reset
//              flush                - drops the held result, blocks input
//              in_valid / in_ready  - input handshake
//              pc, imm, A, B        - branch PC, B-type offset, rs1, rs2
//              funct3, pred_taken   - branch type, prediction used by fetch
//              out_valid/out_ready  - output handshake
//              out_taken, out_mispred, out_redirect, out_illegal - result
//              lk_pc / lk_taken     - fetch-side BHT lookup
//              stat_branches, stat_mispreds - only with BRANCH_STATS_EN
// Config     : BRANCH_STATS_EN adds retired-branch / mispredict counters.
// Revision   : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int N           = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   funct3,
  input  logic         pred_taken,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_taken,
  output logic         out_mispred,
  output logic [N-1:0] out_redirect,
  output logic         out_illegal,
  input  logic [N-1:0] lk_pc,
  output logic         lk_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]  stat_branches,
  output logic [31:0]  stat_mispreds
`endif
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  // --------------------------------------------------------------------------
  // Condition evaluation and target arithmetic
  // --------------------------------------------------------------------------
  logic         w_eq;
  logic         w_lt;
  logic         w_ltu;
  logic         w_taken;
  logic         w_illegal;
  logic [N-1:0] w_target;
  logic [N-1:0] w_seq;

  assign w_eq     = (A == B);
  assign w_lt     = ($signed(A) < $signed(B));
  assign w_ltu    = (A < B);
  assign w_target = pc + imm;
  assign w_seq    = pc + N'(4);

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (br_funct3_e'(funct3))
      BEQ:     w_taken = w_eq;
      BNE:     w_taken = !w_eq;
      BLT:     w_taken = w_lt;
      BGE:     w_taken = !w_lt;
      BLTU:    w_taken = w_ltu;
      BGEU:    w_taken = !w_ltu;
      default: w_illegal = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output stage and handshake
  // --------------------------------------------------------------------------
  logic           out_valid_q,    out_valid_d;
  logic           out_taken_q,    out_taken_d;
  logic           out_mispred_q,  out_mispred_d;
  logic [N-1:0]   out_redirect_q, out_redirect_d;
  logic           out_illegal_q,  out_illegal_d;
  logic [IDX-1:0] out_idx_q,      out_idx_d;

  logic w_accept;
  logic w_out_hs;
  logic w_train;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = out_valid_q && out_ready;
  // A flushed result is discarded, so it must not reach the BHT either.
  assign w_train  = w_out_hs && !out_illegal_q && !flush;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_taken_d    = out_taken_q;
    out_mispred_d  = out_mispred_q;
    out_redirect_d = out_redirect_q;
    out_illegal_d  = out_illegal_q;
    out_idx_d      = out_idx_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      // Also covers a retire and a new accept on the same edge.
      out_valid_d    = 1'b1;
      out_taken_d    = w_taken;
      out_mispred_d  = w_taken ^ pred_taken;
      out_redirect_d = w_taken ? w_target : w_seq;
      out_illegal_d  = w_illegal;
      out_idx_d      = pc[IDX+1:2];
    end else if (w_out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      out_valid_q    <= 1'b0;
      out_taken_q    <= 1'b0;
      out_mispred_q  <= 1'b0;
      out_redirect_q <= '0;
      out_illegal_q  <= 1'b0;
      out_idx_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_taken_q    <= out_taken_d;
      out_mispred_q  <= out_mispred_d;
      out_redirect_q <= out_redirect_d;
      out_illegal_q  <= out_illegal_d;
      out_idx_q      <= out_idx_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_taken    = out_taken_q;
  assign out_mispred  = out_mispred_q;
  assign out_redirect = out_redirect_q;
  assign out_illegal  = out_illegal_q;

  // --------------------------------------------------------------------------
  // Branch history table
  // --------------------------------------------------------------------------
  // Only the word-index bits of the lookup PC select an entry.
  logic w_unused_lk;
  assign w_unused_lk = ^{lk_pc[N-1:IDX+2], lk_pc[1:0]};

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clock      (clock),
    .nReset     (nReset),
    .lk_idx_i   (lk_pc[IDX+1:2]),
    .lk_taken_o (lk_taken),
    .tr_en_i    (w_train),
    .tr_idx_i   (out_idx_q),
    .tr_taken_i (out_taken_q)
  );

  // --------------------------------------------------------------------------
  // Optional retirement statistics
  // --------------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispreds_q, stat_mispreds_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispreds_d = stat_mispreds_q;
    if (w_train) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (out_mispred_q) stat_mispreds_d = stat_mispreds_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      stat_branches_q <= '0;
      stat_mispreds_q <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispreds_q <= stat_mispreds_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispreds = stat_mispreds_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_branch_resolve_unit
// Description: Scoreboard bench for branch_resolve_unit. Expected results are
//              queued when a branch is accepted and compared while the DUT
//              presents them; a reference BHT tracks retired branches.
// Config     : BRANCH_STATS_EN enables the statistics checks.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        clk;
  logic        nReset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  funct3;
  logic        pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_mispred;
  logic [31:0] out_redirect;
  logic        out_illegal;
  logic [31:0] lk_pc;
  logic        lk_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispreds;
`endif

  branch_resolve_unit #(
    .N           (32),
    .BHT_ENTRIES (16)
  ) dut (
    .clock        (clk),
    .nReset       (nReset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc           (pc),
    .imm          (imm),
    .A            (A),
    .B            (B),
    .funct3       (funct3),
    .pred_taken   (pred_taken),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_taken    (out_taken),
    .out_mispred  (out_mispred),
    .out_redirect (out_redirect),
    .out_illegal  (out_illegal),
    .lk_pc        (lk_pc),
    .lk_taken     (lk_taken)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispreds (stat_mispreds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        taken;
    logic        mispred;
    logic [31:0] redirect;
    logic        illegal;
    logic [3:0]  idx;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_bht [16];
  logic       tr_pend = 1'b0;
  logic [3:0] tr_idx;
  logic       tr_tk;
  logic       tr_mp;
  int         m_br = 0;
  int         m_mp = 0;

  function automatic exp_t model(input logic [31:0] p, input logic [31:0] i,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f, input logic pr);
    exp_t e;
    e.taken   = 1'b0;
    e.illegal = 1'b0;
    case (f)
      3'd0:    e.taken = (a == b);
      3'd1:    e.taken = (a != b);
      3'd4:    e.taken = ($signed(a) <  $signed(b));
      3'd5:    e.taken = ($signed(a) >= $signed(b));
      3'd6:    e.taken = (a <  b);
      3'd7:    e.taken = (a >= b);
      default: e.illegal = 1'b1;
    endcase
    e.mispred  = (e.taken != pr);
    e.redirect = e.taken ? (p + i) : (p + 32'd4);
    e.idx      = p[5:2];
    return e;
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int k = 0; k < 16; k++) m_bht[k] = 2'b01;
    tr_pend = 1'b0;
    m_br    = 0;
    m_mp    = 0;
  endtask

  // Compare the head of the scoreboard every cycle the DUT holds a result;
  // retire it on handshake, drop it on flush, and queue newly accepted work.
  always @(negedge clk) begin
    exp_t e;
    if (nReset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb[0];
          chk("out_taken",    out_taken,    e.taken);
          chk("out_mispred",  out_mispred,  e.mispred);
          chk("out_redirect", out_redirect, e.redirect);
          chk("out_illegal",  out_illegal,  e.illegal);
          if (flush) begin
            void'(sb.pop_front());
          end else if (out_ready) begin
            void'(sb.pop_front());
            if (!e.illegal) begin
              tr_pend = 1'b1;
              tr_idx  = e.idx;
              tr_tk   = e.taken;
              tr_mp   = e.mispred;
            end
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(pc, imm, A, B, funct3, pred_taken));
    end
  end

  // Reference BHT updates on the same edge as the DUT.
  always @(posedge clk) begin
    if (tr_pend) begin
      if (tr_tk) begin
        if (m_bht[tr_idx] != 2'b11) m_bht[tr_idx] = m_bht[tr_idx] + 2'b01;
      end else begin
        if (m_bht[tr_idx] != 2'b00) m_bht[tr_idx] = m_bht[tr_idx] - 2'b01;
      end
      m_br++;
      if (tr_mp) m_mp++;
      tr_pend = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] f, input logic pr);
    logic acc;
    acc = 1'b0;
    @(posedge clk); #1;
    pc = p; imm = i; A = a; B = b; funct3 = f; pred_taken = pr;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0 && !tr_pend) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic lk_model(input string tag, input logic [31:0] p);
    lk_pc = p; #1;
    chk(tag, lk_taken, m_bht[p[5:2]][1]);
  endtask

  task automatic lk_const(input string tag, input logic [31:0] p, input logic exp);
    lk_pc = p; #1;
    chk(tag, lk_taken, exp);
  endtask

  // Table of condition / arithmetic patterns: pc, imm, A, B, funct3, pred.
  typedef struct packed {
    logic [31:0] p;
    logic [31:0] i;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        pr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h0000_1000, 32'h0000_0010, 32'd3,          32'd4,          3'd1, 1'b1};
    vecs[1]  = '{32'h0000_1000, 32'h0000_0010, 32'd9,          32'd9,          3'd1, 1'b0};
    vecs[2]  = '{32'h0000_1000, 32'hFFFF_FFF0, 32'h8000_0000,  32'h7FFF_FFFF,  3'd4, 1'b0};
    vecs[3]  = '{32'h0000_1000, 32'hFFFF_FFF0, 32'h8000_0000,  32'h7FFF_FFFF,  3'd5, 1'b1};
    vecs[4]  = '{32'h0000_1000, 32'h0000_0100, 32'h8000_0000,  32'h7FFF_FFFF,  3'd6, 1'b1};
    vecs[5]  = '{32'h0000_1000, 32'h0000_0100, 32'h8000_0000,  32'h7FFF_FFFF,  3'd7, 1'b0};
    vecs[6]  = '{32'h0000_1000, 32'h0000_0100, 32'd7,          32'd7,          3'd5, 1'b0};
    vecs[7]  = '{32'h0000_1000, 32'h0000_0100, 32'd7,          32'd7,          3'd7, 1'b0};
    vecs[8]  = '{32'hFFFF_FFF0, 32'h0000_0020, 32'd1,          32'd1,          3'd0, 1'b1};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0020, 32'd1,          32'd2,          3'd0, 1'b0};
    vecs[10] = '{32'h0000_1000, 32'h0000_0007, 32'd0,          32'd1,          3'd4, 1'b1};
    vecs[11] = '{32'h0000_1000, 32'h0000_0010, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  3'd6, 1'b1};
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    nReset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pc = '0; imm = '0; A = '0; B = '0; funct3 = '0; pred_taken = 1'b0; lk_pc = '0;
    model_reset();

    // Reset state.
    #2;
    chk("rst_out_valid",    out_valid,    0);
    chk("rst_out_taken",    out_taken,    0);
    chk("rst_out_mispred",  out_mispred,  0);
    chk("rst_out_redirect", out_redirect, 0);
    chk("rst_out_illegal",  out_illegal,  0);
    chk("rst_lk_taken",     lk_taken,     0);
    #10 nReset = 1'b1;

    // Saturation up and down at pc 0x40.
    lk_const("t3_lk_init", 32'h40, 1'b0);
    for (int k = 0; k < 3; k++) begin
      send(32'h40, 32'h10, 32'd1, 32'd1, 3'd0, 1'b0);
      drain();
      lk_const("t3_lk_up", 32'h40, 1'b1);
      lk_model("t3_lk_up_model", 32'h40);
    end
    chk("t3_ctr_sat_hi", m_bht[0], 2'b11);
    for (int k = 0; k < 4; k++) begin
      send(32'h40, 32'h10, 32'd1, 32'd1, 3'd1, 1'b1);
      drain();
      lk_const("t3_lk_down", 32'h40, (k == 0) ? 1'b1 : 1'b0);
    end
    chk("t3_ctr_sat_lo", m_bht[0], 2'b00);

    // Basic beq taken.
    send(32'h100, 32'h20, 32'd5, 32'd5, 3'd0, 1'b0);
    chk("t1_valid",    out_valid,    1);
    chk("t1_taken",    out_taken,    1);
    chk("t1_redirect", out_redirect, 32'h120);
    chk("t1_mispred",  out_mispred,  1);
    drain();

    // Signed vs unsigned compare of -1 and 1.
    send(32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'd4, 1'b0);
    chk("t2_blt_taken", out_taken, 1);
    drain();
    send(32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 3'd6, 1'b0);
    chk("t2_bltu_taken",    out_taken,    0);
    chk("t2_bltu_redirect", out_redirect, 32'h304);
    drain();

    // Pattern table, including wraparound of both adders.
    for (int k = 0; k < 12; k++) begin
      send(vecs[k].p, vecs[k].i, vecs[k].a, vecs[k].b, vecs[k].f, vecs[k].pr);
    end
    drain();
    lk_model("tbl_lk_c", 32'hFFFF_FFF0);
    lk_model("tbl_lk_f", 32'hFFFF_FFFC);

    // Backpressure, then retire and accept on the same edge.
    out_ready = 1'b0;
    send(32'h500, 32'h8, 32'd2, 32'd3, 3'd6, 1'b1);
    pc = 32'h504; imm = 32'h40; A = 32'd3; B = 32'd2; funct3 = 3'd5; pred_taken = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_in_ready", in_ready,  0);
      chk("t4_stall_valid",    out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_reload_valid",    out_valid,    1);
    chk("t4_reload_redirect", out_redirect, 32'h544);
    drain();

    // Flush discards the held result without training.
    out_ready = 1'b0;
    send(32'h48, 32'h8, 32'd7, 32'd7, 3'd0, 1'b0);
    lk_const("t5_lk_before", 32'h48, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1;
    pc = 32'h600; imm = 32'h4; A = '0; B = '0; funct3 = 3'd0; pred_taken = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t5_flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_valid", out_valid, 0);
    lk_const("t5_lk_after", 32'h48, 1'b0);
    drain();

    // Illegal funct3 is reported and leaves the BHT alone.
    send(32'h4C, 32'h8, 32'd1, 32'd1, 3'd0, 1'b1);
    drain();
    lk_const("t5_lk_trained", 32'h4C, 1'b1);
    send(32'h4C, 32'h8, 32'd1, 32'd1, 3'd2, 1'b1);
    chk("t5_ill_illegal",  out_illegal,  1);
    chk("t5_ill_taken",    out_taken,    0);
    chk("t5_ill_mispred",  out_mispred,  1);
    chk("t5_ill_redirect", out_redirect, 32'h50);
    drain();
    lk_const("t5_lk_ill", 32'h4C, 1'b1);
    send(32'h4C, 32'h8, 32'd1, 32'd1, 3'd3, 1'b0);
    chk("t5_ill3_illegal", out_illegal, 1);
    drain();
    lk_model("t5_lk_ill3", 32'h4C);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(32'h700, 32'h8, 32'd1, 32'd2, 3'd1, 1'b0);
    #3;
    nReset = 1'b0;
    #1;
    chk("t6_rst_valid",   out_valid,   0);
    chk("t6_rst_taken",   out_taken,   0);
    chk("t6_rst_illegal", out_illegal, 0);
    model_reset();
    for (int k = 0; k < 16; k++) lk_const("t6_rst_lk", 32'(k) << 2, 1'b0);
    @(negedge clk); #2;
    nReset = 1'b1;
    out_ready = 1'b1;

    // Ten retired branches after reset, three of them mispredicted.
    for (int k = 0; k < 10; k++) begin
      send(32'h200 + 32'(k) * 32'd4, 32'h10, 32'd4, 32'd4, 3'd0, (k < 3) ? 1'b0 : 1'b1);
    end
    drain();
    chk("t6_model_branches", m_br, 10);
    chk("t6_model_mispreds", m_mp, 3);
`ifdef BRANCH_STATS_EN
    chk("t6_stat_branches", stat_branches, 32'd10);
    chk("t6_stat_mispreds", stat_mispreds, 32'd3);
`endif
    for (int k = 0; k < 16; k++) lk_model("t6_lk_final", 32'(k) << 2);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
